// File: rtl/dlx_commit_trace_if.sv
// Bundle between the fetch stage, the commit-trace block and the record consumer.
// The slave modport is the trace block's view; master is the driver/consumer side.
interface dlx_commit_trace_if;
    logic [31:0] iw_in;
    logic [31:0] pc_in;
    logic        iw_en;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_iw;
    logic [31:0] rec_pc;
    logic [5:0]  rec_opcode;
    logic [1:0]  rec_type;
    logic [4:0]  rec_rs1;
    logic [4:0]  rec_rs2;
    logic [4:0]  rec_rd;
    logic [25:0] rec_imm;
    logic [3:0]  rec_count;
    logic        ovf;
    logic [15:0] drop_cnt;

    modport master (
        output iw_in, pc_in, iw_en, rec_ready,
        input  rec_valid, rec_iw, rec_pc, rec_opcode, rec_type,
               rec_rs1, rec_rs2, rec_rd, rec_imm, rec_count, ovf, drop_cnt
    );

    modport slave (
        input  iw_in, pc_in, iw_en, rec_ready,
        output rec_valid, rec_iw, rec_pc, rec_opcode, rec_type,
               rec_rs1, rec_rs2, rec_rd, rec_imm, rec_count, ovf, drop_cnt
    );
endinterface

// File: rtl/dlx_commit_trace.sv
// DLX commit trace: delay line of fetched words feeding a show-ahead record FIFO.
// Optional macro DLX_TRACE_DROP_COUNT_EN enables the saturating drop counter.
module dlx_commit_trace #(
    parameter int DELAY      = 6,
    parameter int FIFO_DEPTH = 8
) (
    input logic              clk,
    input logic              rst,
    dlx_commit_trace_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = $clog2(DELAY + 1);

    typedef struct packed {
        logic [31:0] iw;
        logic [31:0] pc;
    } stage_t;

    stage_t          line_q [DELAY];
    stage_t          line_d [DELAY];
    stage_t          mem_q  [FIFO_DEPTH];
    stage_t          mem_d  [FIFO_DEPTH];
    logic [WW-1:0]   warm_q, warm_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            push;
    logic            pop;
    logic            full;
    logic            drop;
    logic            accept;
    stage_t          head;

    always_comb begin
        push   = bus.iw_en && (warm_q == WW'(DELAY));
        pop    = (count_q != '0) && bus.rec_ready;
        full   = (count_q == CW'(FIFO_DEPTH));
        // A simultaneous pop frees the slot, so a full FIFO only drops without one.
        drop   = push && full && !pop;
        accept = push && !drop;
    end

    always_comb begin
        for (int k = 0; k < DELAY; k++) begin
            line_d[k] = line_q[k];
        end
        warm_d = warm_q;
        if (bus.iw_en) begin
            line_d[0] = {bus.iw_in, bus.pc_in};
            for (int k = 1; k < DELAY; k++) begin
                line_d[k] = line_q[k-1];
            end
            if (warm_q != WW'(DELAY)) begin
                warm_d = warm_q + WW'(1);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            mem_d[k] = mem_q[k];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | drop;
        if (accept) begin
            mem_d[wr_ptr_q] = line_q[DELAY-1];
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (accept && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !accept) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DELAY; k++) begin
                line_q[k] <= '0;
            end
            warm_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            for (int k = 0; k < DELAY; k++) begin
                line_q[k] <= line_d[k];
            end
            warm_q   <= warm_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Record storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            mem_q[k] <= mem_d[k];
        end
    end

    always_comb begin
        head           = mem_q[rd_ptr_q];
        bus.rec_valid  = (count_q != '0);
        bus.rec_iw     = head.iw;
        bus.rec_pc     = head.pc;
        bus.rec_opcode = head.iw[31:26];
        bus.rec_count  = 4'(count_q);
        bus.ovf        = ovf_q;
        bus.rec_type   = 2'b01;
        bus.rec_rs1    = head.iw[25:21];
        bus.rec_rs2    = 5'd0;
        bus.rec_rd     = head.iw[20:16];
        bus.rec_imm    = {10'd0, head.iw[15:0]};
        if (head.iw[31:26] == 6'h00) begin
            bus.rec_type = 2'b00;
            bus.rec_rs2  = head.iw[20:16];
            bus.rec_rd   = head.iw[15:11];
            bus.rec_imm  = '0;
        end else if (head.iw[31:26] == 6'h02 || head.iw[31:26] == 6'h03) begin
            bus.rec_type = 2'b10;
            bus.rec_rs1  = '0;
            bus.rec_rd   = '0;
            bus.rec_imm  = head.iw[25:0];
        end
    end

`ifdef DLX_TRACE_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    assign bus.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_dlx_commit_trace.sv
// Directed bench for dlx_commit_trace: decode, latency, overflow, wrap, stall and reset.
// Expected drop count follows DLX_TRACE_DROP_COUNT_EN when it is defined for the build.
module tb_dlx_commit_trace;
    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   exp_drop;

    dlx_commit_trace_if bus();

    dlx_commit_trace #(
        .DELAY      (6),
        .FIFO_DEPTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the edge, so outputs are sampled away from it.
    task automatic applyStimulus(input logic rst_n, input logic en, input logic ready,
                                 input logic [31:0] iw, input logic [31:0] pc);
        rst           = rst_n;
        bus.iw_en     = en;
        bus.rec_ready = ready;
        bus.iw_in     = iw;
        bus.pc_in     = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkRecord(input string tag, input int exp_imm, input logic [31:0] exp_pc);
        checkOutput({tag, ".valid"}, 32'(bus.rec_valid), 32'd1);
        checkOutput({tag, ".imm"},   32'(bus.rec_imm),   32'(exp_imm));
        checkOutput({tag, ".pc"},    bus.rec_pc,         exp_pc);
    endtask

    function automatic logic [31:0] addi(input int i);
        logic [31:0] w;
        w       = 32'h2000_0000;
        w[15:0] = 16'(i);
        return w;
    endfunction

    task automatic doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef DLX_TRACE_DROP_COUNT_EN
        exp_drop = 2;
`else
        exp_drop = 0;
`endif
        rst = 1'b0;
        doReset();
        checkOutput("reset.valid", 32'(bus.rec_valid), 32'd0);
        checkOutput("reset.count", 32'(bus.rec_count), 32'd0);
        checkOutput("reset.ovf",   32'(bus.ovf),       32'd0);
        checkOutput("reset.drop",  32'(bus.drop_cnt),  32'd0);

        // Decode and latency: ADDI, R-type, J-type, then LW fillers.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h2001_0005, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0043_0820, 32'h4);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0800_000C, 32'h8);
        for (int i = 3; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1, 32'h8C22_0010, 32'(4 * i));
        checkOutput("lat.edge6.valid", 32'(bus.rec_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h8C22_0010, 32'd24);
        checkOutput("addi.valid",  32'(bus.rec_valid),  32'd1);
        checkOutput("addi.iw",     bus.rec_iw,          32'h2001_0005);
        checkOutput("addi.opcode", 32'(bus.rec_opcode), 32'h08);
        checkOutput("addi.type",   32'(bus.rec_type),   32'd1);
        checkOutput("addi.rs1",    32'(bus.rec_rs1),    32'd0);
        checkOutput("addi.rs2",    32'(bus.rec_rs2),    32'd0);
        checkOutput("addi.rd",     32'(bus.rec_rd),     32'd1);
        checkOutput("addi.imm",    32'(bus.rec_imm),    32'h5);
        checkOutput("addi.pc",     bus.rec_pc,          32'h0);
        checkOutput("addi.count",  32'(bus.rec_count),  32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h8C22_0010, 32'd28);
        checkOutput("rtype.type",  32'(bus.rec_type),   32'd0);
        checkOutput("rtype.rs1",   32'(bus.rec_rs1),    32'd2);
        checkOutput("rtype.rs2",   32'(bus.rec_rs2),    32'd3);
        checkOutput("rtype.rd",    32'(bus.rec_rd),     32'd1);
        checkOutput("rtype.imm",   32'(bus.rec_imm),    32'd0);
        checkOutput("rtype.pc",    bus.rec_pc,          32'h4);
        checkOutput("rtype.count", 32'(bus.rec_count),  32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h8C22_0010, 32'd32);
        checkOutput("jtype.type",   32'(bus.rec_type),   32'd2);
        checkOutput("jtype.opcode", 32'(bus.rec_opcode), 32'h02);
        checkOutput("jtype.imm",    32'(bus.rec_imm),    32'h00000C);
        checkOutput("jtype.rs1",    32'(bus.rec_rs1),    32'd0);
        checkOutput("jtype.rd",     32'(bus.rec_rd),     32'd0);
        checkOutput("jtype.pc",     bus.rec_pc,          32'h8);

        // Overflow: 10 records into an 8-deep FIFO, then drain in order.
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 1'b0, addi(i), 32'h100 + 32'(4 * i));
        checkOutput("ovf.count", 32'(bus.rec_count), 32'd8);
        checkOutput("ovf.flag",  32'(bus.ovf),       32'd1);
        checkOutput("ovf.drop",  32'(bus.drop_cnt),  32'(exp_drop));
        for (int k = 0; k < 8; k++) begin
            checkRecord($sformatf("ovf.drain%0d", k), k, 32'h100 + 32'(4 * k));
            applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        end
        checkOutput("ovf.empty.valid", 32'(bus.rec_valid), 32'd0);
        checkOutput("ovf.empty.count", 32'(bus.rec_count), 32'd0);
        checkOutput("ovf.sticky",      32'(bus.ovf),       32'd1);

        // Full FIFO with push and pop together across pointer wrap.
        doReset();
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, 1'b0, addi(i), 32'h200 + 32'(4 * i));
        checkOutput("wrap.full.count", 32'(bus.rec_count), 32'd8);
        for (int m = 1; m <= 10; m++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, addi(13 + m), 32'h200 + 32'(4 * (13 + m)));
            checkOutput($sformatf("wrap%0d.count", m), 32'(bus.rec_count), 32'd8);
            checkRecord($sformatf("wrap%0d", m), m, 32'h200 + 32'(4 * m));
        end
        checkOutput("wrap.ovf", 32'(bus.ovf), 32'd0);

        // Enable held low for three cycles mid-stream.
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, addi(i), 32'h300 + 32'(4 * i));
        checkOutput("stall.pre.count", 32'(bus.rec_count), 32'd2);
        for (int g = 0; g < 3; g++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            checkOutput($sformatf("stall.gap%0d.count", g), 32'(bus.rec_count), 32'd2);
        end
        for (int i = 8; i < 11; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, addi(i), 32'h300 + 32'(4 * i));
            checkOutput($sformatf("stall.post%0d.count", i), 32'(bus.rec_count), 32'(i - 5));
        end
        for (int k = 0; k < 5; k++) begin
            checkRecord($sformatf("stall.drain%0d", k), k, 32'h300 + 32'(4 * k));
            applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        end
        checkOutput("stall.empty", 32'(bus.rec_valid), 32'd0);

        // Reset with five records buffered; warm-up must restart from zero.
        doReset();
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b1, 1'b0, addi(i), 32'h400 + 32'(4 * i));
        checkOutput("rst.pre.count", 32'(bus.rec_count), 32'd5);
        applyStimulus(1'b0, 1'b1, 1'b1, addi(99), 32'h0);
        checkOutput("rst.valid", 32'(bus.rec_valid), 32'd0);
        checkOutput("rst.count", 32'(bus.rec_count), 32'd0);
        for (int j = 0; j < 6; j++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, addi(40 + j), 32'h500 + 32'(4 * j));
            checkOutput($sformatf("rst.warm%0d.valid", j + 1), 32'(bus.rec_valid), 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, addi(46), 32'h518);
        checkRecord("rst.first", 40, 32'h500);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
